hash_display_ctrl: RTL and testbench

//   Frame-synchronous scheduler that feeds the 160-bit hash bus of the VGA hash

---
 rtl/hash_display_ctrl_pkg.sv | 13 +
 rtl/rr_arb2.sv | 20 ++
 rtl/hash_display_ctrl.sv | 124 ++++++++++++
 tb/tb_hash_display_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hash_display_ctrl_pkg.sv
// Shared definitions for the hash display scheduler: FSM state encoding and
// the default hash bus width.
package hash_display_ctrl_pkg;

    localparam int HASH_W_DEFAULT = 160;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PEND = 2'd1,
        S_HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. On contention the requester that did not
// win last time is granted; a lone requester always wins.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/hash_display_ctrl.sv
// Frame-synchronous hash display scheduler: arbitrates two producers, stages the
// accepted hash and commits it to the display only at a frame boundary.
module hash_display_ctrl
    import hash_display_ctrl_pkg::*;
#(
    parameter int HASH_W      = HASH_W_DEFAULT,
    parameter int HOLD_FRAMES = 60,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              clear,
    input  logic              req0_valid,
    input  logic [HASH_W-1:0] req0_hash,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [HASH_W-1:0] req1_hash,
    output logic              req1_ready,
    output logic [HASH_W-1:0] disp_hash,
    output logic              disp_src,
    output logic              disp_valid,
    output logic              busy
);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_FRAMES - 1);

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [HASH_W-1:0] shadow_q, shadow_d;
    logic              shadow_src_q, shadow_src_d;
    logic [HASH_W-1:0] disp_hash_q, disp_hash_d;
    logic              disp_src_q, disp_src_d;
    logic              disp_valid_q, disp_valid_d;
    logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [1:0]        grant;
    logic              xfer;

    rr_arb2 u_arb (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            shadow_q     <= '0;
            shadow_src_q <= 1'b0;
            disp_hash_q  <= '0;
            disp_src_q   <= 1'b0;
            disp_valid_q <= 1'b0;
            hold_cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of its peers.
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            shadow_q     <= shadow_d;
            shadow_src_q <= shadow_src_d;
            disp_hash_q  <= disp_hash_d;
            disp_src_q   <= disp_src_d;
            disp_valid_q <= disp_valid_d;
            hold_cnt_q   <= hold_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (xfer) state_d = S_PEND;
                S_PEND:  if (frame_start) state_d = S_HOLD;
                S_HOLD:  if (hold_cnt_q == '0) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        shadow_d     = shadow_q;
        shadow_src_d = shadow_src_q;
        disp_hash_d  = disp_hash_q;
        disp_src_d   = disp_src_q;
        disp_valid_d = disp_valid_q;
        hold_cnt_d   = hold_cnt_q;
        if (clear) begin
            disp_valid_d = 1'b0;
            disp_hash_d  = '0;
            hold_cnt_d   = '0;
        end else begin
            if (state_q == S_IDLE && xfer) begin
                shadow_d     = req1_ready ? req1_hash : req0_hash;
                shadow_src_d = req1_ready;
                last_grant_d = req1_ready;
            end
            // Commit only on a frame boundary so the picture never tears.
            if (state_q == S_PEND && frame_start) begin
                disp_hash_d  = shadow_q;
                disp_src_d   = shadow_src_q;
                disp_valid_d = 1'b1;
                hold_cnt_d   = HOLD_LOAD;
            end
            if (state_q == S_HOLD && hold_cnt_q != '0 && frame_start) begin
                hold_cnt_d = hold_cnt_q - CNT_W'(1);
            end
        end
    end

    always_comb begin
        req0_ready = (state_q == S_IDLE) && grant[0] && !clear;
        req1_ready = (state_q == S_IDLE) && grant[1] && !clear;
        xfer       = req0_ready || req1_ready;
        busy       = (state_q != S_IDLE);
    end

    assign disp_hash  = disp_hash_q;
    assign disp_src   = disp_src_q;
    assign disp_valid = disp_valid_q;

endmodule

// File: tb/tb_hash_display_ctrl.sv
// Self-checking bench for hash_display_ctrl: directed scenarios followed by a
// randomized phase, all compared against a transaction-level reference model.
module tb_hash_display_ctrl;

    localparam int HW   = 160;
    localparam int HOLD = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          frame_start;
    logic          clear;
    logic          r0_valid, r1_valid;
    logic [HW-1:0] r0_hash, r1_hash;
    logic          req0_ready, req1_ready;
    logic [HW-1:0] disp_hash;
    logic          disp_src, disp_valid, busy;

    hash_display_ctrl #(.HASH_W(HW), .HOLD_FRAMES(HOLD), .CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .clear       (clear),
        .req0_valid  (r0_valid),
        .req0_hash   (r0_hash),
        .req0_ready  (req0_ready),
        .req1_valid  (r1_valid),
        .req1_hash   (r1_hash),
        .req1_ready  (req1_ready),
        .disp_hash   (disp_hash),
        .disp_src    (disp_src),
        .disp_valid  (disp_valid),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: an optional staged hash, a displayed hash with a
    // remaining-frames budget, and the identity of the last winner.
    bit          m_pend, m_hold, m_last, m_sh_src, m_dsrc, m_dval;
    int          m_left;
    logic [HW-1:0] m_sh, m_disp;

    bit auto_drop;
    bit q_src[$];

    task automatic check(input string tag, input logic [HW-1:0] obs, input logic [HW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = 0; m_hold = 0; m_left = 0; m_last = 1;
        m_sh = '0; m_sh_src = 0; m_disp = '0; m_dsrc = 0; m_dval = 0;
    endtask

    task automatic step(input bit fs, input bit clr);
        bit idle, any, win, e0, e1, a0, a1;
        frame_start = fs;
        clear       = clr;
        #1;
        idle = !m_pend && !m_hold && !clr;
        any  = r0_valid || r1_valid;
        win  = (r0_valid && r1_valid) ? !m_last : r1_valid;
        e0   = idle && any && !win;
        e1   = idle && any && win;
        check1("req0_ready", req0_ready, e0);
        check1("req1_ready", req1_ready, e1);
        a0 = req0_ready && r0_valid;
        a1 = req1_ready && r1_valid;
        @(posedge clk);
        if (clr) begin
            m_pend = 0; m_hold = 0; m_left = 0; m_disp = '0; m_dval = 0;
        end else if (idle && any) begin
            m_pend = 1; m_sh = win ? r1_hash : r0_hash; m_sh_src = win; m_last = win;
        end else if (m_pend) begin
            if (fs) begin
                m_pend = 0; m_hold = 1; m_left = HOLD - 1;
                m_disp = m_sh; m_dsrc = m_sh_src; m_dval = 1;
            end
        end else if (m_hold) begin
            if (m_left == 0) m_hold = 0;
            else if (fs) m_left--;
        end
        #1;
        check("disp_hash", disp_hash, m_disp);
        check1("disp_src", disp_src, m_dsrc);
        check1("disp_valid", disp_valid, m_dval);
        check1("busy", busy, m_pend || m_hold);
        frame_start = 0;
        clear       = 0;
        if (a0) begin q_src.push_back(1'b0); if (auto_drop) r0_valid = 0; end
        if (a1) begin q_src.push_back(1'b1); if (auto_drop) r1_valid = 0; end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1; r0_valid = 0; r1_valid = 0;
        model_reset();
        @(negedge clk);
        rst = 0;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [HW-1:0] h_a, h_b, h_c, h_d, h_e, h_prev;
        int n;
        rst = 1; frame_start = 0; clear = 0;
        r0_valid = 0; r1_valid = 0; r0_hash = '0; r1_hash = '0;
        auto_drop = 1;
        model_reset();

        // 1: reset state, idle frames do nothing
        #1;
        check("rst_disp_hash", disp_hash, '0);
        check1("rst_disp_valid", disp_valid, 1'b0);
        check1("rst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        repeat (3) step(1, 0);

        // 2: single producer, commit at next frame, hold for HOLD frames
        h_a = 160'h0123456789ABCDEF0123456789ABCDEF01234567;
        q_src.delete();
        r0_hash = h_a; r0_valid = 1;
        step(0, 0);
        check("t2_accept_cnt", HW'(q_src.size()), HW'(1));
        step(0, 0);
        step(1, 0);
        check("t2_commit_hash", disp_hash, h_a);
        check1("t2_commit_src", disp_src, 1'b0);
        check1("t2_commit_valid", disp_valid, 1'b1);
        step(0, 0);
        step(1, 0);
        check("t2_held_hash", disp_hash, h_a);
        r0_hash = {$urandom, $urandom, $urandom, $urandom, $urandom};
        r0_valid = 1;
        step(0, 0);
        step(0, 0);
        check("t2_reaccept_cnt", HW'(q_src.size()), HW'(2));
        h_b = r0_hash;
        step(1, 0);
        check("t2_second_commit", disp_hash, h_b);

        // 3: continuous contention alternates, req0 first after reset
        do_reset();
        auto_drop = 0;
        h_a = {5{32'hAAAA_5555}};
        h_b = {5{32'hBBBB_4444}};
        r0_hash = h_a; r1_hash = h_b; r0_valid = 1; r1_valid = 1;
        q_src.delete();
        for (int i = 0; i < 200 && q_src.size() < 4; i++) step(i % 3 == 0, 0);
        check1("t3_enough_grants", q_src.size() >= 4, 1'b1);
        if (q_src.size() >= 4) begin
            check1("t3_grant0", q_src[0], 1'b0);
            check1("t3_grant1", q_src[1], 1'b1);
            check1("t3_grant2", q_src[2], 1'b0);
            check1("t3_grant3", q_src[3], 1'b1);
        end

        // 4: transfer in a frame_start cycle does not bypass to the display
        auto_drop = 1;
        r0_valid = 0; r1_valid = 0;
        for (int i = 0; i < 50 && busy; i++) step(1, 0);
        check1("t4_idle", busy, 1'b0);
        h_prev = m_disp;
        h_c = {$urandom, $urandom, $urandom, $urandom, $urandom};
        r0_hash = h_c; r0_valid = 1;
        n = q_src.size();
        step(1, 0);
        check("t4_accept_cnt", HW'(q_src.size()), HW'(n + 1));
        check("t4_no_bypass", disp_hash, h_prev);
        step(1, 0);
        check("t4_commit", disp_hash, h_c);

        // 5: clear during hold blanks the display; pending req1 accepted next
        h_d = {$urandom, $urandom, $urandom, $urandom, $urandom};
        r1_hash = h_d; r1_valid = 1;
        step(0, 1);
        check1("t5_valid", disp_valid, 1'b0);
        check("t5_hash", disp_hash, '0);
        check1("t5_busy", busy, 1'b0);
        n = q_src.size();
        step(0, 0);
        check("t5_accept_cnt", HW'(q_src.size()), HW'(n + 1));
        check1("t5_accept_src", q_src[q_src.size() - 1], 1'b1);

        // 6: async reset mid-pend discards the staged hash
        step(1, 0);
        check("t6_commit_d", disp_hash, h_d);
        step(1, 0);
        step(0, 0);
        h_e = {$urandom, $urandom, $urandom, $urandom, $urandom};
        r0_hash = h_e; r0_valid = 1;
        step(0, 0);
        check1("t6_pending", busy, 1'b1);
        #2;
        rst = 1;
        #1;
        check("t6_async_hash", disp_hash, '0);
        check1("t6_async_valid", disp_valid, 1'b0);
        check1("t6_async_busy", busy, 1'b0);
        r0_valid = 0; r1_valid = 0;
        model_reset();
        @(negedge clk);
        rst = 0;
        step(1, 0);
        check1("t6_no_commit", disp_valid, 1'b0);
        step(1, 0);

        // Randomized traffic against the reference model
        auto_drop = 1;
        for (int i = 0; i < 1500; i++) begin
            if (!r0_valid && $urandom_range(2) == 0) begin
                r0_hash = {$urandom, $urandom, $urandom, $urandom, $urandom};
                r0_valid = 1;
            end
            if (!r1_valid && $urandom_range(2) == 0) begin
                r1_hash = {$urandom, $urandom, $urandom, $urandom, $urandom};
                r1_valid = 1;
            end
            step($urandom_range(5) == 0, $urandom_range(49) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
